// File: rtl/decoder_sequencer_if.sv
// Bus between a controller and decoder_sequencer: mode/select/dwell controls in,
// registered one-hot decode plus Active/Wrap status out.
interface decoder_sequencer_if #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
);
  localparam int OUTS = 2 ** SEL_W;

  logic               Enable;
  logic [1:0]         Mode;
  logic [SEL_W-1:0]   Sel;
  logic               Load;
  logic [DWELL_W-1:0] Dwell;
  logic [OUTS-1:0]    Y;
  logic               Active;
  logic               Wrap;

  modport master (
    output Enable, Mode, Sel, Load, Dwell,
    input  Y, Active, Wrap
  );

  modport slave (
    input  Enable, Mode, Sel, Load, Dwell,
    output Y, Active, Wrap
  );
endinterface

// File: rtl/decoder_sequencer.sv
// Registered 1-of-OUTS decoder with LEVEL, PULSE and SCAN modes; SCAN rotates
// through the outputs holding each for Dwell+1 cycles and flags index wrap.
module decoder_sequencer #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  decoder_sequencer_if.slave bus
);
  localparam int OUTS = 2 ** SEL_W;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_PULSE = 2'b01,
    MODE_SCAN  = 2'b10,
    MODE_RSVD  = 2'b11
  } modeE;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stateE;

  stateE              state, stateNext;
  logic [SEL_W-1:0]   index, indexNext, indexInc;
  logic [DWELL_W-1:0] dwellCnt, dwellCntNext;
  logic [OUTS-1:0]    yReg, yNext;
  logic               activeReg, wrapReg, wrapNext;
  modeE               mode;
  logic               scanReq;

  function automatic logic [OUTS-1:0] oneHot(input logic [SEL_W-1:0] code);
    logic [OUTS-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

  assign mode     = modeE'(bus.Mode);
  assign scanReq  = bus.Enable && (mode == MODE_SCAN);
  assign indexInc = index + 1'b1;

  // NOTE: every output of this block is written with a default first, so no
  // path through the case statements can leave a latch behind.
  always_comb begin
    stateNext    = state;
    indexNext    = index;
    dwellCntNext = dwellCnt;
    yNext        = '0;
    wrapNext     = 1'b0;
    unique case (state)
      IDLE: begin
        if (scanReq) begin
          stateNext    = RUN;
          indexNext    = bus.Sel;
          dwellCntNext = bus.Dwell;
          yNext        = oneHot(bus.Sel);
        end else if (bus.Enable) begin
          case (mode)
            MODE_PULSE: yNext = bus.Load ? oneHot(bus.Sel) : '0;
            MODE_SCAN:  yNext = '0;
            default:    yNext = oneHot(bus.Sel);  // LEVEL and reserved
          endcase
        end
      end
      RUN: begin
        if (!scanReq) begin
          // Leaving the scan drops the output for one edge; no index survives.
          stateNext    = IDLE;
          indexNext    = '0;
          dwellCntNext = '0;
        end else if (dwellCnt != '0) begin
          dwellCntNext = dwellCnt - 1'b1;
          yNext        = oneHot(index);
        end else begin
          // Dwell is resampled only here and at entry.
          indexNext    = indexInc;
          dwellCntNext = bus.Dwell;
          yNext        = oneHot(indexInc);
          wrapNext     = (index == SEL_W'(OUTS - 1));
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register sees
  // pre-edge values; reset here is synchronous and overrides all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      index     <= '0;
      dwellCnt  <= '0;
      yReg      <= '0;
      activeReg <= 1'b0;
      wrapReg   <= 1'b0;
    end else begin
      state     <= stateNext;
      index     <= indexNext;
      dwellCnt  <= dwellCntNext;
      yReg      <= yNext;
      activeReg <= |yNext;
      wrapReg   <= wrapNext;
    end
  end

  assign bus.Y      = yReg;
  assign bus.Active = activeReg;
  assign bus.Wrap   = wrapReg;
endmodule

// File: tb/tb_decoder_sequencer.sv
// Scoreboard bench for decoder_sequencer: drivers queue hand-computed expectations,
// monitors pop and compare one entry per cycle on the falling edge.
module tb_decoder_sequencer;
  logic clk;
  logic rst;

  decoder_sequencer_if #(.SEL_W(2), .DWELL_W(4)) busA ();
  decoder_sequencer_if #(.SEL_W(3), .DWELL_W(4)) busB ();

  decoder_sequencer #(.SEL_W(2), .DWELL_W(4)) dutA (.clk(clk), .rst(rst), .bus(busA));
  decoder_sequencer #(.SEL_W(3), .DWELL_W(4)) dutB (.clk(clk), .rst(rst), .bus(busB));

  typedef struct {
    logic [7:0] y;
    logic       wrap;
    string      tag;
  } expT;

  expT qA[$];
  expT qB[$];
  int  compared = 0;
  int  failed   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs to DUT A and queue what must appear after the next edge.
  task automatic stepA(input logic r, input logic en, input logic [1:0] md,
                       input logic [1:0] sel, input logic ld, input logic [3:0] dw,
                       input logic [3:0] expY, input logic expWrap, input string tag);
    expT e;
    @(negedge clk);
    rst          = r;
    busA.Enable  = en;
    busA.Mode    = md;
    busA.Sel     = sel;
    busA.Load    = ld;
    busA.Dwell   = dw;
    #1;
    e.y    = {4'b0000, expY};
    e.wrap = expWrap;
    e.tag  = tag;
    qA.push_back(e);
  endtask

  task automatic stepB(input logic en, input logic [1:0] md, input logic [2:0] sel,
                       input logic [3:0] dw, input logic [7:0] expY,
                       input logic expWrap, input string tag);
    expT e;
    @(negedge clk);
    rst         = 1'b0;
    busB.Enable = en;
    busB.Mode   = md;
    busB.Sel    = sel;
    busB.Load   = 1'b0;
    busB.Dwell  = dw;
    #1;
    e.y    = expY;
    e.wrap = expWrap;
    e.tag  = tag;
    qB.push_back(e);
  endtask

  always @(negedge clk) begin
    expT e;
    if (qA.size() != 0) begin
      e = qA.pop_front();
      check({e.tag, ".Y"},      {4'b0000, busA.Y}, e.y);
      check({e.tag, ".Active"}, {7'b0, busA.Active}, {7'b0, |e.y});
      check({e.tag, ".Wrap"},   {7'b0, busA.Wrap}, {7'b0, e.wrap});
    end
  end

  always @(negedge clk) begin
    expT e;
    if (qB.size() != 0) begin
      e = qB.pop_front();
      check({e.tag, ".Y"},      busB.Y, e.y);
      check({e.tag, ".Active"}, {7'b0, busB.Active}, {7'b0, |e.y});
      check({e.tag, ".Wrap"},   {7'b0, busB.Wrap}, {7'b0, e.wrap});
    end
  end

  // One-hot-or-zero must hold in every cycle of every scenario.
  always @(negedge clk) begin
    assert ($onehot0(busA.Y)) else begin
      failed++;
      $display("FAIL onehotA: got %b expected at most one bit set", busA.Y);
    end
    assert ($onehot0(busB.Y)) else begin
      failed++;
      $display("FAIL onehotB: got %b expected at most one bit set", busB.Y);
    end
  end

  initial begin
    logic [3:0] scanExp [10];
    logic [3:0] reExp   [6];
    logic [2:0] idx;

    rst = 1'b1;
    busA.Enable = 1'b0; busA.Mode = 2'b00; busA.Sel = '0; busA.Load = 1'b0; busA.Dwell = '0;
    busB.Enable = 1'b0; busB.Mode = 2'b00; busB.Sel = '0; busB.Load = 1'b0; busB.Dwell = '0;

    // Reset dominates an enabled SCAN request; scan starts on the first free edge.
    stepA(1, 1, 2'b10, 2'd2, 0, 4'd1, 4'b0000, 0, "rst0");
    stepA(1, 1, 2'b10, 2'd2, 0, 4'd1, 4'b0000, 0, "rst1");

    // SCAN from 2 with Dwell=1; Sel moved to 0 after entry must be ignored.
    stepA(0, 1, 2'b10, 2'd2, 0, 4'd1, 4'b0100, 0, "scanEntry");
    scanExp = '{4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001,
                4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
    for (int i = 0; i < 10; i++)
      stepA(0, 1, 2'b10, 2'd0, 0, 4'd1, scanExp[i], (i == 3), $sformatf("scan%0d", i));
    stepA(0, 0, 2'b10, 2'd0, 0, 4'd1, 4'b0000, 0, "abortEnable");

    // Re-entry from Sel=3 with Dwell=0 advances every cycle and wraps every four.
    reExp = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 6; i++)
      stepA(0, 1, 2'b10, 2'd3, 0, 4'd0, reExp[i], (i == 1 || i == 5), $sformatf("reScan%0d", i));
    stepA(0, 1, 2'b00, 2'd1, 0, 4'd0, 4'b0000, 0, "exitToLevel");

    // LEVEL sweep, reserved mode behaves as LEVEL, then disable.
    for (int i = 0; i < 4; i++)
      stepA(0, 1, 2'b00, 2'(i), 0, 4'd0, 4'(1 << i), 0, $sformatf("level%0d", i));
    stepA(0, 1, 2'b11, 2'd2, 0, 4'd0, 4'b0100, 0, "levelRsvd");
    stepA(0, 0, 2'b00, 2'd2, 0, 4'd0, 4'b0000, 0, "levelOff");

    // Entry with Sel=0 must not flag Wrap.
    stepA(0, 1, 2'b10, 2'd0, 0, 4'd0, 4'b0001, 0, "entrySel0");
    stepA(0, 1, 2'b10, 2'd0, 0, 4'd0, 4'b0010, 0, "entrySel0Adv");
    stepA(0, 1, 2'b01, 2'd0, 0, 4'd0, 4'b0000, 0, "exitToPulse");

    // PULSE: single strobe, then a three-cycle burst following Sel each edge.
    stepA(0, 1, 2'b01, 2'd2, 1, 4'd0, 4'b0100, 0, "pulseSingle");
    stepA(0, 1, 2'b01, 2'd2, 0, 4'd0, 4'b0000, 0, "pulseGap");
    stepA(0, 1, 2'b01, 2'd1, 1, 4'd0, 4'b0010, 0, "pulseBurst0");
    stepA(0, 1, 2'b01, 2'd3, 1, 4'd0, 4'b1000, 0, "pulseBurst1");
    stepA(0, 1, 2'b01, 2'd0, 1, 4'd0, 4'b0001, 0, "pulseBurst2");
    stepA(0, 1, 2'b01, 2'd0, 0, 4'd0, 4'b0000, 0, "pulseEnd");
    stepA(0, 0, 2'b01, 2'd3, 1, 4'd0, 4'b0000, 0, "pulseDisabled");

    // Dwell change mid-period takes effect only at the next advance.
    stepA(0, 1, 2'b10, 2'd1, 0, 4'd2, 4'b0010, 0, "dwellEntry");
    stepA(0, 1, 2'b10, 2'd3, 0, 4'd0, 4'b0010, 0, "dwellHold1");
    stepA(0, 1, 2'b10, 2'd3, 0, 4'd0, 4'b0010, 0, "dwellHold2");
    stepA(0, 1, 2'b10, 2'd3, 0, 4'd0, 4'b0100, 0, "dwellAdv1");
    stepA(0, 1, 2'b10, 2'd3, 0, 4'd0, 4'b1000, 0, "dwellAdv2");

    // Reset just before a wrap aborts with no Wrap pulse; then a fresh PULSE edge.
    stepA(1, 1, 2'b10, 2'd3, 0, 4'd0, 4'b0000, 0, "rstMidScan");
    stepA(1, 1, 2'b01, 2'd3, 1, 4'd0, 4'b0000, 0, "rstOverPulse");
    stepA(0, 1, 2'b01, 2'd3, 1, 4'd0, 4'b1000, 0, "postRstPulse");
    stepA(0, 0, 2'b00, 2'd0, 0, 4'd0, 4'b0000, 0, "idleA");

    // Eight-output scan from 5 with Dwell=0: full rotation, Wrap once per eight cycles.
    for (int k = 0; k < 17; k++) begin
      idx = 3'(5 + k);
      stepB(1, 2'b10, 3'd5, 4'd0, 8'(1 << idx), (k > 0 && idx == 3'd0), $sformatf("scan8_%0d", k));
    end
    stepB(0, 2'b10, 3'd5, 4'd0, 8'b0000_0000, 0, "scan8Off");

    repeat (3) @(negedge clk);
    check("drain", 8'(qA.size() + qB.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
